// File: rtl/decode_ex_pipe_pkg.sv
// Shared types for the rv32i decode/execute boundary.
// alu_op_t is the ALU operation encoding carried from decode into execute.
package decode_ex_pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_t;

endpackage

// File: rtl/decode_ex_pipe.sv
// ID/EX pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush, and write-back bypass on captured and held operands.
module decode_ex_pipe
    import decode_ex_pipe_pkg::*;
#(
    parameter int DPW = 32,
    parameter int ADW = 5,
    parameter int IMW = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           resultsrcD,
    input  logic           memwriteD,
    input  logic           alusrcD,
    input  logic           regwriteD,
    input  alu_op_t        alu_ctrlD,
    input  logic [DPW-1:0] rd_1,
    input  logic [DPW-1:0] rd_2,
    input  logic [ADW-1:0] Rs1D,
    input  logic [ADW-1:0] Rs2D,
    input  logic [ADW-1:0] RdD,
    input  logic [IMW-1:0] immextD,
    input  logic           wb_we,
    input  logic [ADW-1:0] wb_addr,
    input  logic [DPW-1:0] wb_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           resultsrcE,
    output logic           memwriteE,
    output logic           alusrcE,
    output logic           regwriteE,
    output alu_op_t        alu_ctrlE,
    output logic [DPW-1:0] srcA,
    output logic [DPW-1:0] Rd2E,
    output logic [ADW-1:0] Rs1E,
    output logic [ADW-1:0] Rs2E,
    output logic [ADW-1:0] RdE,
    output logic [IMW-1:0] immextE
);

    typedef struct packed {
        logic           valid;
        logic           resultsrc;
        logic           memwrite;
        logic           alusrc;
        logic           regwrite;
        alu_op_t        alu_ctrl;
        logic [DPW-1:0] rd1;
        logic [DPW-1:0] rd2;
        logic [ADW-1:0] rs1;
        logic [ADW-1:0] rs2;
        logic [ADW-1:0] rd;
        logic [IMW-1:0] imm;
    } entry_t;

    entry_t m_q, s_q;
    entry_t m_d, s_d;
    entry_t cap, m_byp, s_byp;

    logic accept;
    logic m_free;

    // Register x0 is hard-wired zero, so a write-back to it must never bypass.
    function automatic logic wb_hit(input logic           we,
                                    input logic [ADW-1:0] waddr,
                                    input logic [ADW-1:0] a);
        return we && (waddr != '0) && (waddr == a);
    endfunction

    function automatic entry_t bypass(input entry_t         e,
                                      input logic           we,
                                      input logic [ADW-1:0] waddr,
                                      input logic [DPW-1:0] wdata);
        entry_t r;
        r = e;
        if (e.valid && wb_hit(we, waddr, e.rs1)) r.rd1 = wdata;
        if (e.valid && wb_hit(we, waddr, e.rs2)) r.rd2 = wdata;
        return r;
    endfunction

    assign in_ready = !s_q.valid;
    assign accept   = in_valid && in_ready;
    assign m_free   = !m_q.valid || out_ready;

    // NOTE: every variable written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        cap           = '0;
        cap.valid     = 1'b1;
        cap.resultsrc = resultsrcD;
        cap.memwrite  = memwriteD;
        cap.alusrc    = alusrcD;
        cap.regwrite  = regwriteD;
        cap.alu_ctrl  = alu_ctrlD;
        cap.rd1       = wb_hit(wb_we, wb_addr, Rs1D) ? wb_data : rd_1;
        cap.rd2       = wb_hit(wb_we, wb_addr, Rs2D) ? wb_data : rd_2;
        cap.rs1       = Rs1D;
        cap.rs2       = Rs2D;
        cap.rd        = RdD;
        cap.imm       = immextD;

        m_byp = bypass(m_q, wb_we, wb_addr, wb_data);
        s_byp = bypass(s_q, wb_we, wb_addr, wb_data);

        m_d = m_byp;
        s_d = s_byp;

        if (flush) begin
            m_d       = m_q;
            s_d       = s_q;
            m_d.valid = 1'b0;
            s_d.valid = 1'b0;
        end else if (m_free) begin
            if (s_q.valid) begin
                // The skid entry is older than anything arriving, so it advances first.
                m_d       = s_byp;
                s_d.valid = 1'b0;
            end else if (accept) begin
                m_d = cap;
            end else begin
                m_d.valid = 1'b0;
            end
        end else if (accept) begin
            s_d = cap;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    // NOTE: data flops are reset along with the valid bits so the E outputs read
    // zero out of reset rather than X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            s_q <= '0;
        end else begin
            m_q <= m_d;
            s_q <= s_d;
        end
    end

    assign out_valid  = m_q.valid;
    assign regwriteE  = m_q.regwrite && m_q.valid;
    assign memwriteE  = m_q.memwrite && m_q.valid;
    assign resultsrcE = m_q.resultsrc;
    assign alusrcE    = m_q.alusrc;
    assign alu_ctrlE  = m_q.alu_ctrl;
    assign srcA       = m_q.rd1;
    assign Rd2E       = m_q.rd2;
    assign Rs1E       = m_q.rs1;
    assign Rs2E       = m_q.rs2;
    assign RdE        = m_q.rd;
    assign immextE    = m_q.imm;

endmodule

// File: tb/tb_decode_ex_pipe.sv
// Directed bench for decode_ex_pipe: streaming, stall/skid, flush, write-back
// bypass on capture and on held entries, and asynchronous reset mid-stall.
module tb_decode_ex_pipe;
    import decode_ex_pipe_pkg::*;

    localparam int DPW = 32;
    localparam int ADW = 5;
    localparam int IMW = 32;

    logic           clk;
    logic           rst_n;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic           resultsrcD, memwriteD, alusrcD, regwriteD;
    alu_op_t        alu_ctrlD;
    logic [DPW-1:0] rd_1, rd_2;
    logic [ADW-1:0] Rs1D, Rs2D, RdD;
    logic [IMW-1:0] immextD;
    logic           wb_we;
    logic [ADW-1:0] wb_addr;
    logic [DPW-1:0] wb_data;
    logic           out_valid;
    logic           out_ready;
    logic           resultsrcE, memwriteE, alusrcE, regwriteE;
    alu_op_t        alu_ctrlE;
    logic [DPW-1:0] srcA, Rd2E;
    logic [ADW-1:0] Rs1E, Rs2E, RdE;
    logic [IMW-1:0] immextE;

    int n_cmp = 0;
    int n_err = 0;

    decode_ex_pipe #(.DPW(DPW), .ADW(ADW), .IMW(IMW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .resultsrcD (resultsrcD),
        .memwriteD  (memwriteD),
        .alusrcD    (alusrcD),
        .regwriteD  (regwriteD),
        .alu_ctrlD  (alu_ctrlD),
        .rd_1       (rd_1),
        .rd_2       (rd_2),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .immextD    (immextD),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultsrcE (resultsrcE),
        .memwriteE  (memwriteE),
        .alusrcE    (alusrcE),
        .regwriteE  (regwriteE),
        .alu_ctrlE  (alu_ctrlE),
        .srcA       (srcA),
        .Rd2E       (Rd2E),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .immextE    (immextE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        resultsrcD = 1'b0;
        memwriteD  = 1'b0;
        alusrcD    = 1'b0;
        regwriteD  = 1'b0;
        alu_ctrlD  = ALU_ADD;
        rd_1       = '0;
        rd_2       = '0;
        Rs1D       = '0;
        Rs2D       = '0;
        RdD        = '0;
        immextD    = '0;
        wb_we      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        out_ready  = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_immextE", immextE, 0);
        check("rst_srcA", srcA, 0);
        check("rst_regwriteE", regwriteE, 0);
        check("rst_alu_ctrlE", alu_ctrlE, 0);
        step();
        rst_n = 1'b1;

        // Streaming: 8 back-to-back entries, one per cycle, no gaps
        regwriteD = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            immextD = IMW'(i);
            RdD     = ADW'(i);
            step();
            check($sformatf("stream_valid_%0d", i), out_valid, 1);
            check($sformatf("stream_imm_%0d", i), immextE, i);
            check($sformatf("stream_rd_%0d", i), RdE, i);
            check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drain_valid", out_valid, 0);
        check("stream_bubble_regwrite", regwriteE, 0);

        // Stall and skid: M takes 0x21, S takes 0x22, 0x23 waits
        out_ready = 1'b0;
        in_valid  = 1'b1;
        immextD   = 32'h21;
        step();
        check("stall1_imm", immextE, 32'h21);
        check("stall1_in_ready", in_ready, 1);
        immextD = 32'h22;
        step();
        check("stall2_imm", immextE, 32'h21);
        check("stall2_in_ready", in_ready, 0);
        immextD = 32'h23;
        step();
        check("stall3_imm", immextE, 32'h21);
        check("stall3_in_ready", in_ready, 0);
        out_ready = 1'b1;
        step();
        check("release1_imm", immextE, 32'h22);
        check("release1_valid", out_valid, 1);
        check("release1_in_ready", in_ready, 1);
        step();
        check("release2_imm", immextE, 32'h23);
        in_valid = 1'b0;
        step();
        check("release_drain_valid", out_valid, 0);

        // Flush with both entries valid and an input offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        memwriteD = 1'b1;
        immextD   = 32'h31;
        step();
        check("flush_pre_memwrite", memwriteE, 1);
        immextD = 32'h32;
        step();
        check("flush_pre_in_ready", in_ready, 0);
        immextD = 32'h33;
        flush   = 1'b1;
        step();
        check("flush_out_valid", out_valid, 0);
        check("flush_regwrite", regwriteE, 0);
        check("flush_memwrite", memwriteE, 0);
        check("flush_in_ready", in_ready, 1);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("flush_after_valid", out_valid, 0);
        // Flush drops an accept into an empty register
        flush    = 1'b1;
        in_valid = 1'b1;
        immextD  = 32'h34;
        step();
        check("flush_drop_valid", out_valid, 0);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        check("flush_drop_after", out_valid, 0);
        memwriteD = 1'b0;
        regwriteD = 1'b0;

        // Capture bypass
        in_valid  = 1'b1;
        Rs1D      = 5'd5;
        rd_1      = 32'h11;
        alu_ctrlD = ALU_XOR;
        wb_we     = 1'b1;
        wb_addr   = 5'd5;
        wb_data   = 32'hAA;
        step();
        check("cap_byp_srcA", srcA, 32'hAA);
        check("cap_alu_ctrl", alu_ctrlE, ALU_XOR);
        check("cap_rs1", Rs1E, 5);
        wb_addr = 5'd0;
        step();
        check("cap_wb0_srcA", srcA, 32'h11);
        Rs1D = 5'd0;
        step();
        check("cap_x0_srcA", srcA, 32'h11);
        Rs2D    = 5'd6;
        rd_2    = 32'h22;
        wb_addr = 5'd6;
        wb_data = 32'hBB;
        step();
        check("cap_byp_Rd2E", Rd2E, 32'hBB);
        check("cap_nobyp_srcA", srcA, 32'h11);
        in_valid = 1'b0;
        wb_we    = 1'b0;
        step();
        check("cap_drain_valid", out_valid, 0);

        // Held-entry bypass: A (rs2=3) held in M, B (rs2=7) held in S
        out_ready = 1'b0;
        in_valid  = 1'b1;
        immextD   = 32'h41;
        Rs2D      = 5'd3;
        rd_2      = 32'h1;
        step();
        check("held_A_Rd2E", Rd2E, 32'h1);
        immextD = 32'h42;
        Rs2D    = 5'd7;
        rd_2    = 32'h12345678;
        step();
        check("held_A_imm", immextE, 32'h41);
        in_valid = 1'b0;
        wb_we    = 1'b1;
        wb_addr  = 5'd3;
        wb_data  = 32'h55;
        step();
        check("held_M_byp_Rd2E", Rd2E, 32'h55);
        check("held_M_imm", immextE, 32'h41);
        // Write x7 on the cycle B moves from S to M
        out_ready = 1'b1;
        wb_addr   = 5'd7;
        wb_data   = 32'hDEADBEEF;
        step();
        check("held_S_imm", immextE, 32'h42);
        check("held_S_byp_Rd2E", Rd2E, 32'hDEADBEEF);
        wb_we = 1'b0;
        step();
        check("held_drain_valid", out_valid, 0);

        // Async reset mid-stall
        out_ready = 1'b0;
        in_valid  = 1'b1;
        immextD   = 32'h51;
        step();
        immextD = 32'h52;
        step();
        check("arst_pre_in_ready", in_ready, 0);
        check("arst_pre_valid", out_valid, 1);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_immextE", immextE, 0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("arst_after_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decode_ex_pipe.md
# decode_ex_pipe

Parametrised ID/EX pipeline register for the rv32i core. It sits between the decode stage (control unit plus register file read) and the execute stage. It adds a valid/ready handshake with a two-entry skid buffer, a synchronous flush, and write-back bypass so that operands held in the register never go stale while the pipeline is stalled. It supersedes the free-running decode-to-execute register and passes rs1/rs2 addresses through for the execute-stage forwarding unit.

## Interface
- DPW, 32, datapath width of operands rd_1/rd_2 and wb_data
- ADW, 5, register address width
- IMW, 32, immediate width
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- flush  input  1  synchronous kill of every held and incoming entry
- in_valid / in_ready  input / output  1 / 1  decode-side handshake
- resultsrcD, memwriteD, alusrcD, regwriteD  input  1 each  decode control
- alu_ctrlD  input  alu_op_t  ALU operation
- rd_1, rd_2  input  DPW  register file read data
- Rs1D, Rs2D, RdD  input  ADW each  source and destination addresses
- immextD  input  IMW  extended immediate
- wb_we, wb_addr, wb_data  input  1 / ADW / DPW  write-back port, same values driven to reg_file
- out_valid / out_ready  output / input  1 / 1  execute-side handshake
- resultsrcE, memwriteE, alusrcE, regwriteE  output  1 each
- alu_ctrlE  output  alu_op_t
- srcA, Rd2E  output  DPW each
- Rs1E, Rs2E, RdE  output  ADW each
- immextE  output  IMW

## Operation
- Storage consists of two entries: main M, which drives the outputs, and skid S. Each entry has a valid bit plus all D fields.
- in_ready = !S.valid. This is a pure flop output with no combinational path from out_ready.
- accept = in_valid & in_ready. issue = out_valid & out_ready. out_valid = M.valid.
- Next-state rules when flush = 0:
  - M is empty or issuing, and S is valid: S moves to M. Any accepted input goes to S. This case cannot coincide with accept, because in_ready = 0.
  - M is empty or issuing, and S is empty: the accepted input goes to M. With no accept, M.valid becomes 0.
  - M is held (valid and not issuing): the accepted input goes to S. Otherwise S keeps its contents.
- flush = 1: M.valid and S.valid are cleared next edge. A same-cycle accept is dropped. Data fields are left unchanged.
- Output qualification: regwriteE and memwriteE equal the stored bit AND M.valid. A bubble therefore never writes. All other outputs show raw M fields.
- Write-back bypass:
  - match(a) = wb_we & (wb_addr != 0) & (wb_addr == a).
  - On capture, rd_1 is replaced by wb_data if match(Rs1D). rd_2 is replaced by wb_data if match(Rs2D).
  - Every cycle, each valid held entry has its rd1 field overwritten with wb_data if match(its Rs1). The rd2 field is handled the same way with Rs2. This applies even if the entry is moving from S to M that cycle.
  - Address 0 is never bypassed.
- There is no combinational path from any input to any output except in_ready (a flop).

## Timing
- Reset (rst_n low, asynchronous): M.valid = S.valid = 0 and every data flop = 0, with alu_ctrl = alu_op_t'(0). Outputs read out_valid = 0, in_ready = 1, all E outputs 0.
- Latency: an input accepted into empty M appears on outputs 1 cycle later.
- Throughput: 1 entry per cycle while out_ready = 1.
- The first stall cycle (out_ready = 0 with M valid) still accepts one entry into S. in_ready drops on the next cycle.
- in_ready returns 1 one cycle after S drains into M.
- Ordering is strictly FIFO; S is always older than any new input.
- flush has priority over accept, issue, and bypass valid updates.
- A simultaneous flush and issue is legal: the issue completes on the execute side and the state is still cleared.
- If rst_n is asserted mid-stall, both entries are lost and in_ready = 1 immediately, asynchronously.

## Test plan
- Streaming: 8 back-to-back entries with immextD = 1..8 and out_ready = 1 -> out_valid rises 1 cycle after the first accept. immextE sequence is 1..8 with no gaps, and in_ready stays 1.
- Stall and skid: out_ready = 0 for 3 cycles while in_valid = 1 -> exactly 2 entries held. in_ready = 0 from the 2nd stall cycle. After release, entries emerge in order with none lost or duplicated.
- Flush: flush pulsed with both entries valid and in_valid = 1 -> next cycle out_valid = 0, regwriteE = 0, memwriteE = 0, in_ready = 1. The dropped input never appears.
- Capture bypass: Rs1D = 5, rd_1 = 0x11, wb_we = 1, wb_addr = 5, wb_data = 0xAA -> srcA = 0xAA. Repeating with wb_addr = 0 gives srcA = 0x11.
- Held-entry bypass: an entry with Rs2 = 7 is stalled in S. wb writes x7 = 0xDEADBEEF -> Rd2E = 0xDEADBEEF when that entry reaches the outputs.
- Async reset mid-stall: rst_n is dropped between edges -> out_valid = 0 and in_ready = 1 before the next clk edge.
